code_loader: RTL and testbench
==============================

# code_loader

Write-side companion to the 256×32 instruction memory. It accepts a byte stream over a valid/ready handshake and packs every four bytes big-endian into one instruction word. Each word is written into the memory's write port at consecutive addresses starting from 0. The CPU is held in reset until the image is complete, which is marked by the all-ones sentinel word 32'hFFFF_FFFF or by filling address 255.

## Interface
Parameters:
- DEPTH, 256: number of instruction words; the loader writes addresses 0..DEPTH-1.
- ADDR_W, 8: width of mem_addr; DEPTH = 2^ADDR_W.
- SENTINEL, 32'hFFFF_FFFF: terminating word. The sentinel is itself written to memory.

Ports:
- clk  input  1  single clock; all state changes on the rising edge.
- rst_n  input  1  reset, asynchronous, active-low.
- start  input  1  one-cycle request to begin a load; honoured only in IDLE or DONE.
- byte_valid  input  1  byte_data is valid this cycle.
- byte_data  input  8  next image byte; most-significant byte of each word comes first.
- byte_ready  output  1  loader accepts a byte this cycle. A transfer occurs when byte_valid and byte_ready are both 1.
- mem_we  output  1  write strobe to instruction memory; lasts one cycle per word.
- mem_addr  output  ADDR_W  word address for the write.
- mem_wdata  output  32  assembled instruction word.
- busy  output  1  high in LOAD and WRITE.
- done  output  1  high in DONE.
- cpu_hold  output  1  holds the pipeline/PC in reset; high in every state except DONE.
- word_count  output  ADDR_W+1  words written in the current load (0..DEPTH).
- err_noterm  output  1  last load filled address DEPTH-1 without receiving SENTINEL.

## Operation
- All outputs are registered.
- Reset values: byte_ready=0, mem_we=0, mem_addr=0, mem_wdata=0, busy=0, done=0, cpu_hold=1, word_count=0, err_noterm=0. State after reset is IDLE.
- Internal state: addr (ADDR_W bits), byte index bidx (2 bits), shift register sr (32 bits).

State machine:
- IDLE: byte_ready=0. On start, clear addr, bidx, word_count and err_noterm, then go to LOAD.
- LOAD: byte_ready=1.
  - On each transfer: sr <= {sr[23:0], byte_data} and bidx++.
  - On the transfer where bidx==3, go to WRITE and drive mem_wdata to the completed word and mem_addr to addr.
  - Bytes with byte_valid=1 while byte_ready=0 are not consumed; the source holds them.
- WRITE (exactly one cycle): mem_we=1, byte_ready=0, and word_count increments.
  - If the word equals SENTINEL: go to DONE.
  - Else if addr==DEPTH-1: set err_noterm=1 and go to DONE.
  - Otherwise: addr++, bidx=0, and return to LOAD.
- DONE: cpu_hold=0, done=1, byte_ready=0. mem_addr and mem_wdata hold their last values. On start, go to LOAD with the same clearing as IDLE, and cpu_hold returns to 1.

Boundary conditions:
- start in LOAD or WRITE is ignored.
- A partial word left when the stream stalls is held indefinitely; there is no timeout.
- Deasserting rst_n at any point returns all outputs to their reset values immediately. A partial word is discarded and memory already written is left as is.
- addr never wraps. The DEPTH-1 check ends the load first.
- word_count reaches DEPTH only in the err_noterm case or when the sentinel lands at address DEPTH-1.

## Timing
- Throughput is at most one byte per cycle, with byte_ready dropping only during WRITE. The minimum is 5 cycles per word: 4 transfer cycles plus 1 write cycle.
- mem_we asserts in the cycle after the fourth byte's transfer edge, with addr and data stable for that cycle.
- done and cpu_hold=0 take effect in the cycle after the final WRITE cycle.
- start → LOAD takes one cycle, so byte_ready is first high in the cycle after start is sampled.
- Minimum load time for N words with continuous valid: 1 + 5N cycles from start to done.

## Test plan
- Basic load: start, then stream 01 02 03 04 and FF FF FF FF with byte_valid held high.
  - Writes 32'h01020304 @0, then FFFFFFFF @1.
  - done rises 11 cycles after start is sampled.
  - word_count=2, err_noterm=0, cpu_hold falls together with done.
- Backpressure and gaps: drop byte_valid randomly mid-word while streaming 44 20 00 01.
  - Exactly one write of 32'h44200001 @0.
  - No bytes are lost or duplicated, and byte_ready=0 during WRITE.
- No terminator: stream 256 words of 32'h00000000.
  - 256 writes at addresses 0..255, no wrap.
  - word_count=256, err_noterm=1, done=1.
- Sentinel at top: 255 zero words, then FFFFFFFF.
  - Last write goes to address 255; err_noterm=0, word_count=256.
- Reset mid-word: after 2 bytes, pulse rst_n low asynchronously (not aligned to clk).
  - Outputs return to reset values immediately and no write occurs.
  - A new start followed by 4 bytes writes @0.
- Reload and ignored start: start pulsed during LOAD has no effect.
  - In DONE, a new start re-asserts cpu_hold, clears word_count and err_noterm, and writes from address 0 again.

Source files
------------

// File: rtl/code_loader.sv
// Byte-stream loader for the 256x32 instruction memory: packs bytes big-endian
// into words, writes them from address 0 and holds the CPU until the image ends.
module code_loader #(
  parameter int          DEPTH    = 256,
  parameter int          ADDR_W   = 8,
  parameter logic [31:0] SENTINEL = 32'hFFFF_FFFF
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  input  logic              byte_valid,
  input  logic [7:0]        byte_data,
  output logic              byte_ready,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [31:0]       mem_wdata,
  output logic              busy,
  output logic              done,
  output logic              cpu_hold,
  output logic [ADDR_W:0]   word_count,
  output logic              err_noterm
);

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_LOAD  = 2'd1;
  localparam logic [1:0] S_WRITE = 2'd2;
  localparam logic [1:0] S_DONE  = 2'd3;

  localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(DEPTH - 1);

  logic [1:0]        state, state_nx;
  logic [ADDR_W-1:0] addr;
  logic [1:0]        bidx;
  logic [31:0]       sr;
  logic              xfer;
  logic              is_sentinel;
  logic              at_top;

  // byte_ready is registered high exactly while in LOAD, so it gates transfers
  assign xfer        = byte_valid & byte_ready;
  assign is_sentinel = (mem_wdata == SENTINEL);
  assign at_top      = (addr == LAST_ADDR);

  always_comb begin
    state_nx = state;
    case (state)
      S_IDLE, S_DONE: if (start) state_nx = S_LOAD;
      S_LOAD:         if (xfer && bidx == 2'd3) state_nx = S_WRITE;
      S_WRITE:        state_nx = (is_sentinel || at_top) ? S_DONE : S_LOAD;
      default:        state_nx = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= S_IDLE;
      addr       <= '0;
      bidx       <= '0;
      sr         <= '0;
      byte_ready <= 1'b0;
      mem_we     <= 1'b0;
      mem_addr   <= '0;
      mem_wdata  <= '0;
      busy       <= 1'b0;
      done       <= 1'b0;
      cpu_hold   <= 1'b1;
      word_count <= '0;
      err_noterm <= 1'b0;
    end else begin
      state      <= state_nx;
      // Status outputs follow the next state so they are valid in that state's first cycle
      byte_ready <= (state_nx == S_LOAD);
      mem_we     <= (state_nx == S_WRITE);
      busy       <= (state_nx == S_LOAD) || (state_nx == S_WRITE);
      done       <= (state_nx == S_DONE);
      cpu_hold   <= (state_nx != S_DONE);

      case (state)
        S_IDLE, S_DONE: begin
          if (start) begin
            addr       <= '0;
            bidx       <= '0;
            word_count <= '0;
            err_noterm <= 1'b0;
          end
        end
        S_LOAD: begin
          if (xfer) begin
            sr   <= {sr[23:0], byte_data};
            bidx <= bidx + 2'd1;
            if (bidx == 2'd3) begin
              mem_wdata <= {sr[23:0], byte_data};
              mem_addr  <= addr;
            end
          end
        end
        S_WRITE: begin
          word_count <= word_count + 1'b1;
          if (!is_sentinel && at_top) err_noterm <= 1'b1;
          // addr stops at the top instead of wrapping; the load ends there
          if (!is_sentinel && !at_top) begin
            addr <= addr + 1'b1;
            bidx <= '0;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_code_loader.sv
// Directed bench for code_loader: streams hand-built images and checks the
// write log and status outputs against hand-computed values.
module tb_code_loader;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        start = 1'b0;
  logic        byte_valid = 1'b0;
  logic [7:0]  byte_data = 8'h00;
  logic        byte_ready, mem_we, busy, done, cpu_hold, err_noterm;
  logic [7:0]  mem_addr;
  logic [31:0] mem_wdata;
  logic [8:0]  word_count;

  int n_cmp = 0;
  int n_bad = 0;
  int cyc = 0;
  int start_cyc = 0;
  int done_cyc = 0;
  int bad_ready = 0;
  logic [39:0] wq[$];

  code_loader dut (
    .clk(clk), .rst_n(rst_n), .start(start), .byte_valid(byte_valid),
    .byte_data(byte_data), .byte_ready(byte_ready), .mem_we(mem_we),
    .mem_addr(mem_addr), .mem_wdata(mem_wdata), .busy(busy), .done(done),
    .cpu_hold(cpu_hold), .word_count(word_count), .err_noterm(err_noterm)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc++;

  // Write log: each mem_we cycle records {addr, data}
  always @(negedge clk) begin
    if (mem_we) begin
      wq.push_back({mem_addr, mem_wdata});
      if (byte_ready) bad_ready++;
    end
  end

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic pulse_start();
    @(negedge clk) start = 1'b1;
    @(negedge clk) start = 1'b0;
    start_cyc = cyc;
  endtask

  // Leaves byte_valid high so consecutive calls stream back-to-back
  task automatic send_byte(input logic [7:0] b);
    int n = 0;
    byte_valid = 1'b1;
    byte_data  = b;
    while (!byte_ready && n < 100) begin
      @(negedge clk);
      n++;
    end
    if (n >= 100) chk("ready_timeout", byte_ready, 1);
    @(negedge clk);
  endtask

  task automatic send_word(input logic [31:0] w);
    for (int i = 3; i >= 0; i--) send_byte(w[i*8 +: 8]);
  endtask

  task automatic idle(input int n);
    byte_valid = 1'b0;
    repeat (n) @(negedge clk);
  endtask

  task automatic wait_done();
    int n = 0;
    byte_valid = 1'b0;
    while (!done && n < 100) begin
      @(negedge clk);
      n++;
    end
    chk("done_timeout", done, 1);
    done_cyc = cyc;
  endtask

  initial begin
    int seq_bad;
    logic [39:0] last;

    // Reset values
    #12;
    chk("rst_ready", byte_ready, 0);
    chk("rst_we", mem_we, 0);
    chk("rst_addr", mem_addr, 0);
    chk("rst_wdata", mem_wdata, 0);
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    chk("rst_hold", cpu_hold, 1);
    chk("rst_wc", word_count, 0);
    chk("rst_err", err_noterm, 0);
    @(negedge clk) rst_n = 1'b1;
    idle(2);
    chk("idle_ready", byte_ready, 0);

    // Basic load: two words, continuous stream
    wq.delete();
    pulse_start();
    chk("load_ready", byte_ready, 1);
    chk("load_busy", busy, 1);
    send_word(32'h01020304);
    send_word(32'hFFFF_FFFF);
    wait_done();
    // done is seen after the 10th edge following the start edge (11th cycle counting the start cycle)
    chk("basic_latency", done_cyc - start_cyc, 10);
    chk("basic_nwr", wq.size(), 2);
    chk("basic_w0", wq[0], {8'd0, 32'h01020304});
    chk("basic_w1", wq[1], {8'd1, 32'hFFFF_FFFF});
    chk("basic_wc", word_count, 2);
    chk("basic_err", err_noterm, 0);
    chk("basic_hold", cpu_hold, 0);
    chk("basic_busy", busy, 0);

    // Backpressure: gaps inside the word
    wq.delete();
    bad_ready = 0;
    pulse_start();
    chk("reload_hold", cpu_hold, 1);
    chk("reload_wc", word_count, 0);
    send_byte(8'h44); idle(3);
    send_byte(8'h20); idle(1);
    send_byte(8'h00); idle($urandom_range(0, 4));
    send_byte(8'h01); idle(2);
    send_word(32'hFFFF_FFFF);
    wait_done();
    chk("bp_nwr", wq.size(), 2);
    chk("bp_w0", wq[0], {8'd0, 32'h44200001});
    chk("bp_w1", wq[1], {8'd1, 32'hFFFF_FFFF});
    chk("bp_ready_in_write", bad_ready, 0);

    // No terminator: 256 zero words fill the memory
    wq.delete();
    pulse_start();
    for (int i = 0; i < 256; i++) send_word(32'h0);
    wait_done();
    chk("noterm_nwr", wq.size(), 256);
    seq_bad = 0;
    for (int i = 0; i < wq.size(); i++)
      if (wq[i] !== {i[7:0], 32'h0}) seq_bad++;
    chk("noterm_seq", seq_bad, 0);
    chk("noterm_wc", word_count, 256);
    chk("noterm_err", err_noterm, 1);
    chk("noterm_done", done, 1);

    // Sentinel lands on the top address
    wq.delete();
    pulse_start();
    chk("start_clears_err", err_noterm, 0);
    for (int i = 0; i < 255; i++) send_word(32'h0);
    send_word(32'hFFFF_FFFF);
    wait_done();
    chk("top_nwr", wq.size(), 256);
    last = wq[255];
    chk("top_last", last, {8'd255, 32'hFFFF_FFFF});
    chk("top_err", err_noterm, 0);
    chk("top_wc", word_count, 256);

    // Asynchronous reset in the middle of a word
    wq.delete();
    pulse_start();
    send_byte(8'h12);
    send_byte(8'h34);
    byte_valid = 1'b0;
    #2 rst_n = 1'b0;
    #1;
    chk("arst_ready", byte_ready, 0);
    chk("arst_busy", busy, 0);
    chk("arst_hold", cpu_hold, 1);
    chk("arst_addr", mem_addr, 0);
    chk("arst_wdata", mem_wdata, 0);
    chk("arst_wc", word_count, 0);
    #3 rst_n = 1'b1;
    idle(3);
    chk("arst_nwr", wq.size(), 0);
    pulse_start();
    send_word(32'hAABBCCDD);
    idle(2);
    chk("arst_nwr2", wq.size(), 1);
    chk("arst_w0", wq[0], {8'd0, 32'hAABBCCDD});
    chk("arst_busy2", busy, 1);

    // start during LOAD is ignored: partial word and address survive
    send_byte(8'h11);
    byte_valid = 1'b0;
    pulse_start();
    send_byte(8'h22);
    send_byte(8'h33);
    send_byte(8'h44);
    send_word(32'hFFFF_FFFF);
    wait_done();
    chk("ign_nwr", wq.size(), 3);
    chk("ign_w1", wq[1], {8'd1, 32'h11223344});
    chk("ign_w2", wq[2], {8'd2, 32'hFFFF_FFFF});
    chk("ign_wc", word_count, 3);

    // Reload from DONE writes from address 0 again
    wq.delete();
    pulse_start();
    chk("rl_hold", cpu_hold, 1);
    chk("rl_done", done, 0);
    chk("rl_wc", word_count, 0);
    send_word(32'h55667788);
    send_word(32'hFFFF_FFFF);
    wait_done();
    chk("rl_w0", wq[0], {8'd0, 32'h55667788});
    chk("rl_wc2", word_count, 2);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
